// File: rtl/adc_sample_arbiter_pkg.sv
// Shared constants for the ADC sample arbiter: register map and stream field widths.
package adc_sample_arbiter_pkg;

    localparam int SAMPLE_W = 32;
    localparam int CH_W     = 3;

    localparam logic [4:0] ADCARB_REG_ENABLE   = 5'h00;
    localparam logic [4:0] ADCARB_REG_OVERFLOW = 5'h01;
    localparam logic [4:0] ADCARB_REG_STATUS   = 5'h02;
    localparam logic [4:0] ADCARB_REG_DROPCNT  = 5'h10;

endpackage

// File: rtl/adc_sample_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module adc_rr_pick
    import adc_sample_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] valid,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any_valid
);

    int best_off;
    int off;

    // Each requester's distance from rr_ptr; the smallest distance wins.
    always_comb begin
        grant    = '0;
        best_off = NUM_CH;
        off      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            off = (i - int'(rr_ptr) + NUM_CH) % NUM_CH;
            if (valid[i] && off < best_off) begin
                best_off = off;
                grant    = CH_W'(i);
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/adc_sample_arbiter.sv
// Merges NUM_CH ADC sample strobes into one registered valid/ready stream, with a wishbone
// register slave. Define ADCARB_DROPCNT_EN to add per-channel saturating drop counters.
module adc_sample_arbiter
    import adc_sample_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sq_active,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
    input  logic [NUM_CH-1:0]          ch_sample_avail,
    output logic [SAMPLE_W-1:0]        out_sample,
    output logic [CH_W-1:0]            out_ch,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       wb_stb_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_we_i,
    input  logic [15:0]                wb_adr_i,
    input  logic [7:0]                 wb_dat_i,
    output logic [7:0]                 wb_dat_o,
    output logic                       wb_ack_o
);

    logic [NUM_CH-1:0]               slot_valid;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] slot_data;
    logic [NUM_CH-1:0]               enable, overflow;
    logic [NUM_CH-1:0]               cap, granted, ovf_set, ovf_clr;
    logic [CH_W-1:0]                 rr_ptr, grant;
    logic [SAMPLE_W-1:0]             grant_data;
    logic                            any_valid, free, fire;
    logic                            access, wr;
    logic [4:0]                      adr;
    logic [7:0]                      rd_data;
    logic                            unused_bits;

    assign free        = !out_valid || out_ready;
    assign fire        = free && any_valid;
    assign access      = wb_stb_i && wb_cyc_i && !wb_ack_o;
    assign wr          = access && wb_we_i;
    assign adr         = wb_adr_i[4:0];
    assign unused_bits = ^{wb_adr_i[15:5], wb_dat_i};

    adc_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .valid     (slot_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_comb begin
        cap        = '0;
        granted    = '0;
        ovf_set    = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cap[i]     = ch_sample_avail[i] && enable[i] && sq_active;
            granted[i] = fire && (grant == CH_W'(i));
            // A slot emptied by this cycle's grant can take a new sample without loss.
            ovf_set[i] = cap[i] && slot_valid[i] && !granted[i];
            if (grant == CH_W'(i))
                grant_data = slot_data[i];
        end
        ovf_clr = (wr && adr == ADCARB_REG_OVERFLOW) ? wb_dat_i[NUM_CH-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            slot_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!enable[i]) begin
                    slot_valid[i] <= 1'b0;
                end else if (cap[i] && (!slot_valid[i] || granted[i])) begin
                    slot_valid[i] <= 1'b1;
                    slot_data[i]  <= ch_sample[SAMPLE_W*i +: SAMPLE_W];
                end else if (granted[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_ch     <= '0;
            rr_ptr     <= '0;
        end else if (free) begin
            out_valid <= any_valid;
            if (any_valid) begin
                out_sample <= grant_data;
                out_ch     <= grant;
                rr_ptr     <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

`ifdef ADCARB_DROPCNT_EN
    logic [NUM_CH-1:0][7:0] drop_cnt;
    logic [NUM_CH-1:0]      cnt_clr;

    always_comb begin
        cnt_clr = '0;
        for (int i = 0; i < NUM_CH; i++)
            cnt_clr[i] = wr && (adr == ADCARB_REG_DROPCNT + 5'(i));
    end

    // A drop in the same cycle as a clear leaves the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ovf_set[i])
                    drop_cnt[i] <= cnt_clr[i] ? 8'd1 :
                                   (drop_cnt[i] == 8'hFF) ? 8'hFF : drop_cnt[i] + 8'd1;
                else if (cnt_clr[i])
                    drop_cnt[i] <= 8'd0;
            end
        end
    end
`endif

    always_comb begin
        rd_data = 8'h00;
        case (adr)
            ADCARB_REG_ENABLE:   rd_data = 8'(enable);
            ADCARB_REG_OVERFLOW: rd_data = 8'(overflow);
            ADCARB_REG_STATUS:   rd_data = {6'b0, |slot_valid, out_valid};
            default: begin
`ifdef ADCARB_DROPCNT_EN
                for (int i = 0; i < NUM_CH; i++)
                    if (adr == ADCARB_REG_DROPCNT + 5'(i))
                        rd_data = drop_cnt[i];
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            enable   <= '0;
            overflow <= '0;
        end else begin
            wb_ack_o <= access;
            if (access)
                wb_dat_o <= rd_data;
            if (wr && adr == ADCARB_REG_ENABLE)
                enable <= wb_dat_i[NUM_CH-1:0];
            overflow <= (overflow & ~ovf_clr) | ovf_set;
        end
    end

endmodule

// File: tb/tb_adc_sample_arbiter.sv
// Randomised scoreboard bench for adc_sample_arbiter with a transaction-level reference model.
module tb_adc_sample_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sq_active = 1'b1;
    logic [N*32-1:0] ch_sample = '0;
    logic [N-1:0]    ch_sample_avail = '0;
    logic [31:0]     out_sample;
    logic [2:0]      out_ch;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
    logic [15:0]     wb_adr_i = '0;
    logic [7:0]      wb_dat_i = '0;
    logic [7:0]      wb_dat_o;
    logic            wb_ack_o;

    always #5 clk = ~clk;

    adc_sample_arbiter #(.NUM_CH(N)) dut (
        .clk(clk), .rst_n(rst_n), .sq_active(sq_active), .ch_sample(ch_sample),
        .ch_sample_avail(ch_sample_avail), .out_sample(out_sample), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit rnd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one held sample per channel, one output register, round-robin pointer.
    bit [7:0]    m_en, m_ovf;
    int          m_cnt[N];
    bit          slot_v[N];
    logic [31:0] slot_d[N];
    bit          m_ov, m_ack;
    int          m_rr;
    logic [7:0]  m_rd;
    logic [34:0] exp_q[$];
    int          ch_log[$];

    task automatic model_reset();
        m_en = 0; m_ovf = 0; m_ov = 0; m_ack = 0; m_rr = 0; m_rd = 0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; slot_v[i] = 0; slot_d[i] = 0;
        end
        exp_q.delete();
    endtask

    function automatic logic [7:0] rd_model(input logic [4:0] a);
        bit any = 0;
        for (int i = 0; i < N; i++) any |= slot_v[i];
        case (a)
            5'h00: return m_en;
            5'h01: return m_ovf;
            5'h02: return {6'b0, any, m_ov};
            default: begin
`ifdef ADCARB_DROPCNT_EN
                if (a >= 5'h10 && int'(a) < 16 + N) return 8'(m_cnt[int'(a) - 16]);
`endif
                return 8'h00;
            end
        endcase
    endfunction

    task automatic model_step();
        bit free, gv, acc, wr, cap, gr, set, clr;
        int g;
        logic [4:0] a;
        free = !m_ov || out_ready;
        gv = 0; g = 0;
        for (int k = 0; k < N; k++) begin
            int c = (m_rr + k) % N;
            if (!gv && slot_v[c]) begin gv = 1; g = c; end
        end
        if (!free) gv = 0;
        acc = wb_stb_i && wb_cyc_i && !m_ack;
        wr  = acc && wb_we_i;
        a   = wb_adr_i[4:0];
        if (acc) m_rd = rd_model(a);
        if (free) begin
            m_ov = gv;
            if (gv) begin
                exp_q.push_back({3'(g), slot_d[g]});
                m_rr = (g + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            cap = ch_sample_avail[i] && m_en[i] && sq_active;
            gr  = gv && g == i;
            set = cap && slot_v[i] && !gr;
            if (!m_en[i]) slot_v[i] = 0;
            else if (cap && (!slot_v[i] || gr)) begin slot_v[i] = 1; slot_d[i] = ch_sample[32*i +: 32]; end
            else if (gr) slot_v[i] = 0;
            clr = wr && a == 5'h01 && wb_dat_i[i];
            m_ovf[i] = (m_ovf[i] && !clr) || set;
`ifdef ADCARB_DROPCNT_EN
            clr = wr && int'(a) == 16 + i;
            if (set) m_cnt[i] = clr ? 1 : (m_cnt[i] < 255 ? m_cnt[i] + 1 : 255);
            else if (clr) m_cnt[i] = 0;
`endif
        end
        if (wr && a == 5'h00) m_en = wb_dat_i & 8'((1 << N) - 1);
        m_ack = acc;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: out_valid follows the model each cycle; every handshake pops the scoreboard.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", 32'(out_valid), 32'(m_ov));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 32'(out_ch), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_sample", out_sample, e[31:0]);
                        chk("out_ch", 32'(out_ch), 32'(e[34:32]));
                        ch_log.push_back(int'(out_ch));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                ch_sample[32*i +: 32] = $urandom;
                ch_sample_avail[i]    = ($urandom_range(0, 3) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            sq_active = ($urandom_range(0, 15) != 0);
        end
    endtask

    task automatic wb(input bit we, input logic [15:0] a, input logic [7:0] d, output logic [7:0] rd);
        wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d;
        tick();
        chk("wb_ack", 32'(wb_ack_o), 32'd1);
        rd = wb_dat_o;
        if (!we) chk("wb_dat_o", 32'(wb_dat_o), 32'(m_rd));
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
        tick();
        chk("wb_ack_pulse", 32'(wb_ack_o), 32'd0);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] tmp;
        wb(1, a, d, tmp);
    endtask

    task automatic rd_reg(input logic [15:0] a, output logic [7:0] d);
        wb(0, a, d, d);
    endtask

    task automatic strobe(input logic [N-1:0] m, input logic [31:0] base);
        for (int i = 0; i < N; i++) ch_sample[32*i +: 32] = base + 32'(i);
        ch_sample_avail = m;
        tick();
        ch_sample_avail = '0;
    endtask

    task automatic drain();
        out_ready = 1; ch_sample_avail = '0;
        repeat (12) tick();
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_wb_ack", 32'(wb_ack_o), 0);
        chk("rst_wb_dat", 32'(wb_dat_o), 0);
        rst_n = 1;
        tick();
        rd_reg(16'h0000, d); chk("rst_enable", 32'(d), 0);
        rd_reg(16'h0001, d); chk("rst_overflow", 32'(d), 0);
        rd_reg(16'h0002, d); chk("rst_status", 32'(d), 0);

        // All channels at once, twice: strict 0,1,2,3 order from rr_ptr = 0.
        wr_reg(16'h0000, 8'h0F);
        for (int b = 0; b < 2; b++) begin
            ch_log.delete();
            strobe(4'hF, 32'h1000 * 32'(b + 1));
            drain();
            chk("burst_len", 32'(ch_log.size()), 4);
            for (int i = 0; i < 4 && i < ch_log.size(); i++)
                chk("burst_order", 32'(ch_log[i]), 32'(i));
        end

        // Single sample latency: nothing after one edge, output after two.
        ch_sample[64 +: 32] = 32'hA5A5_0002; ch_sample_avail = 4'b0100;
        tick(); ch_sample_avail = '0;
        chk("lat_n1_valid", 32'(out_valid), 0);
        tick();
        chk("lat_n2_valid", 32'(out_valid), 1);
        chk("lat_sample", out_sample, 32'hA5A5_0002);
        chk("lat_ch", 32'(out_ch), 2);
        drain();
        rd_reg(16'h0001, d); chk("lat_overflow", 32'(d), 0);

        // Stalled output: 1 in output, 2 in slot, 3 dropped.
        out_ready = 0;
        strobe(4'b0010, 32'd0);
        ch_sample[32 +: 32] = 32'd2; ch_sample_avail = 4'b0010; tick();
        ch_sample[32 +: 32] = 32'd3; ch_sample_avail = 4'b0010; tick();
        ch_sample_avail = '0; tick();
        ch_sample[32 +: 32] = 32'd1;
        chk("stall_hold", out_sample, 32'd1);
        rd_reg(16'h0002, d); chk("stall_status", 32'(d), 3);
        rd_reg(16'h0001, d); chk("stall_overflow", 32'(d), 2);
        wr_reg(16'h0001, 8'h02);
        rd_reg(16'h0001, d); chk("w1c_overflow", 32'(d), 0);
        drain();

        // Refill of slot 0 in the cycle it is granted: no loss.
        ch_sample[0 +: 32] = 32'd10; ch_sample_avail = 4'b0001; tick();
        ch_sample[0 +: 32] = 32'd11; tick();
        ch_sample_avail = '0;
        drain();
        rd_reg(16'h0001, d); chk("refill_overflow", 32'(d), 0);

        // Ignored strobes: queue stopped, then channel disabled.
        sq_active = 0; strobe(4'b1000, 32'h33); sq_active = 1;
        drain();
        wr_reg(16'h0000, 8'h07);
        strobe(4'b1000, 32'h44);
        drain();
        rd_reg(16'h0001, d); chk("ignored_overflow", 32'(d), 0);
        rd_reg(16'h0002, d); chk("ignored_status", 32'(d), 0);
        wr_reg(16'h0000, 8'h0F);

        // Random traffic with interleaved register accesses.
        rnd = 1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 37 == 0) begin
                int r = $urandom_range(0, 4);
                logic [15:0] a = {11'($urandom), 5'h00};
                case (r)
                    0: wr_reg(a | 16'h0, 8'($urandom));
                    1: wr_reg(a | 16'h1, 8'($urandom));
                    2: wr_reg(a | 16'h10 | 16'($urandom_range(0, 3)), 8'h00);
                    default: begin
                        logic [4:0] ra;
                        case ($urandom_range(0, 4))
                            0: ra = 5'h00; 1: ra = 5'h01; 2: ra = 5'h02;
                            3: ra = 5'h10 | 5'($urandom_range(0, 7));
                            default: ra = 5'($urandom);
                        endcase
                        rd_reg(a | 16'(ra), d);
                    end
                endcase
            end else begin
                tick();
            end
            if (i % 300 == 299) wr_reg(16'h0000, 8'h0F);
        end
        rnd = 0; sq_active = 1;
        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset while an output is held.
        wr_reg(16'h0000, 8'h0F);
        wr_reg(16'h0001, 8'hFF);
        out_ready = 0;
        strobe(4'b0001, 32'h77);
        tick(); tick();
        chk("pre_reset_valid", 32'(out_valid), 1);
        #2 rst_n = 0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_out_sample", out_sample, 0);
        chk("async_out_ch", 32'(out_ch), 0);
        tick(); rst_n = 1; out_ready = 1; tick();
        rd_reg(16'h0000, d); chk("post_rst_enable", 32'(d), 0);
        rd_reg(16'h0001, d); chk("post_rst_overflow", 32'(d), 0);
        rd_reg(16'h0002, d); chk("post_rst_status", 32'(d), 0);

`ifdef ADCARB_DROPCNT_EN
        wr_reg(16'h0000, 8'h01);
        out_ready = 0;
        ch_sample_avail = 4'b0001;
        for (int i = 0; i < 310; i++) begin ch_sample[0 +: 32] = $urandom; tick(); end
        ch_sample_avail = '0;
        rd_reg(16'h0010, d); chk("dropcnt_sat", 32'(d), 255);
        rd_reg(16'h0011, d); chk("dropcnt_other", 32'(d), 0);
        wr_reg(16'h0010, 8'h5A);
        rd_reg(16'h0010, d); chk("dropcnt_clr", 32'(d), 0);
        drain();
`else
        rd_reg(16'h0010, d); chk("dropcnt_absent", 32'(d), 0);
`endif
        drain();
        chk("final_scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
